rcl_job_arbiter: RTL

- Shares one circle/line relation engine (3-beat coef_L/coef_Q input, 2-bit result: 00 no intersection, 01 tangent, 10 two points) among NREQ requesters.
- Round-robin arbitration between requesters. Each granted 30-bit job is serialized into three consecutive engine beats.
- An in-order tag FIFO tracks which requester owns each in-flight job, so each engine result is routed back to that requester.
- Sits between the per-client job sources and the engine instance.

---
 rtl/rcl_job_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rcl_job_arbiter.sv
// Round-robin front end for one shared circle/line relation engine.
// Serialises 30-bit jobs into three beats and routes results back in order.
module rcl_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [30*NREQ-1:0]        req_coef,
    output logic [NREQ-1:0]           req_ready,
    output logic                      eng_in_valid,
    output logic [4:0]                eng_coef_L,
    output logic [4:0]                eng_coef_Q,
    input  logic                      eng_out_valid,
    input  logic [1:0]                eng_out,
    output logic [NREQ-1:0]           resp_valid,
    output logic [1:0]                resp_data,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      err_orphan
);

    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(MAX_OUT);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [29:0]     r_job;
    logic [29:0]     w_job;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_sum;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0] w_rot;
    logic            w_grant;
    logic            w_pop;
    logic            w_orphan;
    logic [IW-1:0]   r_tag [MAX_OUT];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;
    logic            r_ev;
    logic [NREQ-1:0] r_rv;
    logic [1:0]      r_rdat;
    logic            r_orph;

    // Rotate requests so bit 0 is the slot just after the last winner.
    always_comb begin
        w_dbl = {req_valid, req_valid};
        w_rot = NREQ'(w_dbl >> ({1'b0, r_ptr} + (IW+1)'(1)));
        w_sum = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = {1'b0, r_ptr} + (IW+1)'(1) + (IW+1)'(i);
            end
        end
        if (w_sum >= (IW+1)'(NREQ)) begin
            w_win = IW'(w_sum - (IW+1)'(NREQ));
        end else begin
            w_win = IW'(w_sum);
        end
    end

    always_comb begin
        w_job = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_job = req_coef[30*i +: 30];
            end
        end
    end

    assign w_grant  = (r_state == IDLE || r_state == B3)
                    && (|req_valid)
                    && (r_cnt < CW'(MAX_OUT));
    assign w_pop    = eng_out_valid && (r_cnt != '0);
    assign w_orphan = eng_out_valid && (r_cnt == '0);

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: w_state_n = w_grant ? B1 : IDLE;
            B1:   w_state_n = B2;
            B2:   w_state_n = B3;
            B3:   w_state_n = w_grant ? B1 : IDLE;
        endcase
    end

    // r_job shifts each field pair up one slot per beat; zeros fill behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_job   <= '0;
            r_ptr   <= IW'(NREQ - 1);
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_ev    <= 1'b0;
            r_rv    <= '0;
            r_rdat  <= '0;
            r_orph  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ev    <= (w_state_n != IDLE);
            if (w_grant) begin
                r_job <= w_job;
                r_ptr <= w_win;
                r_wr  <= r_wr + AW'(1);
            end else begin
                r_job <= {r_job[24:15], 5'd0, r_job[9:0], 5'd0};
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_rv   <= w_pop ? (NREQ'(1) << r_tag[r_rd]) : '0;
            r_rdat <= w_pop ? eng_out : 2'd0;
            if (w_orphan) begin
                r_orph <= 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag[r_wr] <= w_win;
        end
    end

    assign eng_in_valid = r_ev;
    assign eng_coef_L   = r_job[29:25];
    assign eng_coef_Q   = r_job[14:10];
    assign resp_valid   = r_rv;
    assign resp_data    = r_rdat;
    assign outstanding  = r_cnt;
    assign err_orphan   = r_orph;

endmodule
